// File: rtl/muldiv_sequencer.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply and restoring
// divide, with the pipeline stall that holds the front end while it runs.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [CNT_W-1:0] counter
);

  // Handshake: an op is accepted on the edge where state is IDLE, start=1 and
  // flush=0; done is a one-cycle pulse in DONE, and result holds until the next
  // acceptance. stall is low in DONE so ID/EX advances while done is high.
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_next;

  logic [2:0]        op;
  logic              neg;
  logic [XLEN-1:0]   opnd;   // multiplicand for multiply, divisor for divide
  logic [2*XLEN-1:0] acc;    // {hi, lo}: product, or {remainder, quotient}

  // Operation classification at acceptance
  logic            is_div, signed_a, signed_b, a_neg, b_neg, neg_in;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    is_div   = funct3[2];
    signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = signed_a && rs1_val[XLEN-1];
    b_neg    = signed_b && rs2_val[XLEN-1];
    a_mag    = a_neg ? (~rs1_val + 1'b1) : rs1_val;
    b_mag    = b_neg ? (~rs2_val + 1'b1) : rs2_val;
    // REM takes the dividend sign; everything else the XOR of operand signs
    neg_in   = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div && (rs2_val == '0);
    div_ovf  = is_div && !funct3[0] && (rs1_val == INT_MIN) && (rs2_val == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = funct3[1] ? rs1_val : '1;
    else          special_res = funct3[1] ? '0 : INT_MIN;
  end

  // One iteration of each algorithm
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, acc_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd};
    if (!div_diff[XLEN]) div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else                 div_next = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    acc_next = op[2] ? div_next : mul_next;
  end

  // Sign fix-up and result selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = neg ? (~acc + 1'b1) : acc;
    quo_fix  = neg ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem_fix  = neg ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    case (op)
      3'b000:                 fix_res = acc[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = special ? DONE : CALC;
        CALC:    if (counter == LAST) state_next = FIX;
        FIX:     state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op      <= '0;
      neg     <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
      counter <= '0;
      result  <= '0;
    end else if (flush) begin
      counter <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op      <= funct3;
          neg     <= neg_in;
          opnd    <= is_div ? b_mag : a_mag;
          acc     <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
          counter <= '0;
          if (special) result <= special_res;
        end
        CALC: begin
          acc     <= acc_next;
          counter <= counter + 1'b1;
        end
        FIX:     result <= fix_res;
        default: ;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign stall = ((state == IDLE) && start) || (state == CALC) || (state == FIX);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, stall window, results, special
// divides, flush, ignored start and asynchronous reset mid-operation.
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [5:0]  counter;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .flush   (flush),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .counter (counter)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Accept one op, then count cycles (1 = first cycle after the accepting
  // edge) until done. Optionally pokes start with other operands mid-CALC.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input bit poke);
    int lat;
    int stall_cnt;
    bit seen;
    @(negedge clk);
    start = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b;
    #1 check($sformatf("%s_stall_accept", tag), {31'd0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    lat = 0; stall_cnt = 0; seen = 1'b0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end else begin
        if (stall) stall_cnt++;
        @(negedge clk);
        if (poke) begin
          start   = (i >= 4 && i < 10);
          funct3  = 3'b101;
          rs1_val = 32'd9;
          rs2_val = 32'd3;
        end
      end
    end
    start = 1'b0;
    check($sformatf("%s_done_seen", tag), {31'd0, seen}, 32'd1);
    check($sformatf("%s_latency", tag), lat, exp_lat);
    check($sformatf("%s_stall_cycles", tag), stall_cnt, exp_lat - 1);
    check($sformatf("%s_stall_in_done", tag), {31'd0, stall}, 32'd0);
    check($sformatf("%s_result", tag), result, exp_res);
    @(negedge clk);
    check($sformatf("%s_done_pulse", tag), {31'd0, done}, 32'd0);
    check($sformatf("%s_busy_after", tag), {31'd0, busy}, 32'd0);
    check($sformatf("%s_result_hold", tag), result, exp_res);
  endtask

  task automatic check_zero_outputs(input string tag);
    check($sformatf("%s_stall", tag), {31'd0, stall}, 32'd0);
    check($sformatf("%s_busy", tag), {31'd0, busy}, 32'd0);
    check($sformatf("%s_done", tag), {31'd0, done}, 32'd0);
    check($sformatf("%s_result", tag), result, 32'd0);
    check($sformatf("%s_counter", tag), {26'd0, counter}, 32'd0);
  endtask

  initial begin
    int n;
    int done_cnt;
    reset_n = 1'b0; start = 1'b0; funct3 = 3'b000;
    rs1_val = '0; rs2_val = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset_n = 1'b1;

    // Multiplies
    run_op("mul_7_m3",  3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b0);
    run_op("mulh_m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, 1'b0);
    run_op("mulhu_ff",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b0);
    run_op("mulhsu_ff", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 1'b0);

    // Special divides
    run_op("divu_by0",  3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF, 1, 1'b0);
    run_op("remu_by0",  3'b111, 32'h1234,     32'd0,        32'h00001234, 1, 1'b0);
    run_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
    run_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1'b0);

    // Signed divides
    run_op("rem_m7_2",  3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 1'b0);
    run_op("div_m7_2",  3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1'b0);
    run_op("divu_100_7", 3'b101, 32'd100,     32'd7,        32'd14,       34, 1'b0);

    // Flush at counter 10 of a DIV
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; rs1_val = 32'd1000; rs2_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (counter != 6'd10 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("flush_reach_cnt10", {26'd0, counter}, 32'd10);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_stall", {31'd0, stall}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_counter", {26'd0, counter}, 32'd0);
    check("flush_result_kept", result, 32'd14);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("flush_no_done", done_cnt, 32'd0);

    // Start while in CALC is ignored
    run_op("mul_ignored_start", 3'b000, 32'd1000, 32'd1000, 32'd1000000, 34, 1'b1);

    // Reset asserted during FIX (cycle 33 after accept)
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rs1_val = 32'd11; rs2_val = 32'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    check("fix_stall_before_reset", {31'd0, stall}, 32'd1);
    #2 reset_n = 1'b0;
    #1 check_zero_outputs("reset_in_fix");
    @(negedge clk);
    check("reset_in_fix_no_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    run_op("mul_3_5", 3'b000, 32'd3, 32'd5, 32'd15, 34, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
